sram_like_ram_slave: RTL and testbench

//  Responder end of the sram-like bus that the core's sram->sram-like bridges drive.

---
 rtl/sram_like_pkg.sv | 35 +++
 rtl/sram_like_resp_pipe.sv | 49 ++++
 rtl/sram_like_ram_slave.sv | 120 ++++++++++++
 tb/tb_sram_like_ram_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// ----------------------------------------------------------------------------
// sram_like_pkg
//   Shared definitions for the sram-like responder:
//     SIZE_BYTE / SIZE_HALF / SIZE_WORD   encodings of the 2-bit size field
//     size2strb(size, lo)                 byte-lane write strobe for a request
//     is_misaligned(size, lo)             request whose lanes do not fit the word
// ----------------------------------------------------------------------------
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 is handled like a word access.
    function automatic logic [3:0] size2strb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << lo;
            SIZE_HALF: strb = 4'b0011 << lo;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lo[0];
            default:   bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sram_like_resp_pipe.sv
// ----------------------------------------------------------------------------
// sram_like_resp_pipe
//   LATENCY-deep shift line of {valid, word}. An entry pushed in cycle T is
//   presented as data_ok/rdata in cycle T+LATENCY.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous reset, active-low (clears valid bits only)
//     in_vld   in   push an entry this cycle (request handshake)
//     in_data  in   RAM word read in the handshake cycle
//     data_ok  out  response pulse
//     rdata    out  response word, forced to 0 when data_ok is low
// ----------------------------------------------------------------------------
module sram_like_resp_pipe #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    output logic        data_ok,
    output logic [31:0] rdata
);

    logic [LATENCY-1:0] vld_p;
    logic [31:0]        data_p [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Data stages are not reset; the output gate below hides stale words.
    always_ff @(posedge clk) begin
        data_p[0] <= in_data;
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
        end
    end

    assign data_ok = vld_p[LATENCY-1];
    assign rdata   = data_ok ? data_p[LATENCY-1] : 32'h0;

endmodule

// File: rtl/sram_like_ram_slave.sv
// ----------------------------------------------------------------------------
// sram_like_ram_slave
//   Responder end of the sram-like bus. Accepts requests on req&addr_ok and
//   returns one in-order data_ok pulse per request exactly LATENCY cycles
//   after the handshake. Backed by a 2^ADDR_W-word RAM indexed by
//   addr[ADDR_W+1:2]; higher address bits alias.
//   Optional build macro: SRAM_LIKE_STALL_INJECT_EN -- a 16-bit LFSR
//   randomly withholds addr_ok to exercise the master's hold logic.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous reset, active-low
//     req      in   request valid, held until addr_ok
//     wr       in   1=write 0=read
//     size     in   0=byte 1=half 2/3=word
//     addr     in   byte address
//     wdata    in   write data, lanes aligned to addr[1:0]
//     addr_ok  out  request accepted when req&addr_ok (independent of req)
//     data_ok  out  one-cycle response pulse
//     rdata    out  full RAM word read at the handshake (0 unless data_ok)
// ----------------------------------------------------------------------------
module sram_like_ram_slave
    import sram_like_pkg::*;
#(
    parameter int    ADDR_W    = 12,
    parameter int    LATENCY   = 3,
    parameter int    MAX_OUTST = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [3:0]        strb;
    logic              hs;
    logic              wr_en;
    logic              room_ok;
    logic [CNT_W-1:0]  cnt;
    logic              unused_addr_hi;

    assign word_idx       = addr[ADDR_W+1:2];
    assign unused_addr_hi = ^addr[31:ADDR_W+2];
    assign rd_word        = mem[word_idx];
    assign strb           = size2strb(size, addr[1:0]);

    // A slot frees up in the same cycle a response leaves, so a full
    // responder can still accept while data_ok is high.
    assign room_ok = (cnt < CNT_W'(MAX_OUTST)) | data_ok;

`ifdef SRAM_LIKE_STALL_INJECT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign addr_ok = rst & room_ok & ~lfsr[0];
`else
    assign addr_ok = rst & room_ok;
`endif

    assign hs    = req & addr_ok;
    assign wr_en = hs & wr & ~is_misaligned(size, addr[1:0]);

    // Outstanding-request counter: +1 on accept, -1 on response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            case ({hs, data_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Writes commit at the handshake edge; the pipe captures the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    sram_like_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (hs),
        .in_data (rd_word),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_sram_like_ram_slave.sv
module tb_sram_like_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    sram_like_ram_slave #(
        .ADDR_W    (12),
        .LATENCY   (3),
        .MAX_OUTST (2),
        .INIT_FILE ("")
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One request, waits for acceptance and its response; checks latency and
    // optionally the returned word.
    task automatic single(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input string nm,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int t_hs;
        int waited;
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
        #1;
        waited = 0;
        while (!addr_ok && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL %s accept: addr_ok=%b required 1", nm, addr_ok);
        else n_pass++;
        t_hs = cyc;
        @(negedge clk);
        req = 1'b0;
        #1;
        waited = 0;
        while (data_ok !== 1'b1 && waited < 10) begin
            @(negedge clk); #1; waited++;
        end
        n_total++;
        if (data_ok !== 1'b1 || cyc - t_hs != 3)
            $display("FAIL %s latency: data_ok=%b after %0d cycles, required 3", nm, data_ok, cyc - t_hs);
        else n_pass++;
        if (chk_rd) begin
            n_total++;
            if (rdata !== exp_rd) $display("FAIL %s rdata: got %h required %h", nm, rdata, exp_rd);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (addr_ok !== 1'b0) $display("FAIL reset addr_ok: got %b required 0", addr_ok); else n_pass++;
        n_total++;
        if (data_ok !== 1'b0) $display("FAIL reset data_ok: got %b required 0", data_ok); else n_pass++;
        n_total++;
        if (rdata !== 32'h0) $display("FAIL reset rdata: got %h required 0", rdata); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
`ifndef SRAM_LIKE_STALL_INJECT_EN
        #1;
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL post-reset addr_ok: got %b required 1", addr_ok); else n_pass++;
`endif
    endtask

    task automatic test_word_rw();
        single(1'b1, 2'd2, 32'h1000, 32'hDEADBEEF, "word_wr", 1'b0, 32'h0);
        single(1'b0, 2'd2, 32'h1000, 32'h0, "word_rd", 1'b1, 32'hDEADBEEF);
    endtask

    task automatic test_strobe();
        single(1'b1, 2'd0, 32'h1002, 32'h005A0000, "byte_wr", 1'b1, 32'hDEADBEEF);
        single(1'b0, 2'd2, 32'h1000, 32'h0, "byte_rd", 1'b1, 32'hDE5ABEEF);
        single(1'b1, 2'd1, 32'h1002, 32'h12340000, "half_wr", 1'b1, 32'hDE5ABEEF);
        single(1'b0, 2'd2, 32'h1000, 32'h0, "half_rd", 1'b1, 32'h1234BEEF);
    endtask

    task automatic test_misaligned();
        single(1'b1, 2'd2, 32'h1001, 32'hFFFFFFFF, "misal_word_wr", 1'b1, 32'h1234BEEF);
        single(1'b1, 2'd1, 32'h1001, 32'hFFFFFFFF, "misal_half_wr", 1'b0, 32'h0);
        single(1'b0, 2'd2, 32'h1003, 32'h0, "misal_rd", 1'b1, 32'h1234BEEF);
        single(1'b0, 2'd2, 32'h5000, 32'h0, "alias_rd", 1'b1, 32'h1234BEEF);
    endtask

`ifndef SRAM_LIKE_STALL_INJECT_EN
    task automatic test_back_to_back();
        logic exp_ok [4];
        int   hs_cyc [4];
        int   issued;
        int   resp;
        exp_ok = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            single(1'b1, 2'd2, 32'(i * 4), 32'hA0000000 | 32'(i), "b2b_init", 1'b0, 32'h0);
        end
        issued = 0;
        resp = 0;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k < 4) begin
                n_total++;
                if (addr_ok !== exp_ok[k]) $display("FAIL b2b addr_ok T+%0d: got %b required %b", k, addr_ok, exp_ok[k]);
                else n_pass++;
            end
            if (data_ok === 1'b1) begin
                n_total++;
                if (resp >= 4 || cyc - hs_cyc[resp] != 3 || rdata !== (32'hA0000000 | 32'(resp)))
                    $display("FAIL b2b resp %0d: rdata=%h at T+%0d", resp, rdata, k);
                else n_pass++;
                resp++;
            end
            if (req && addr_ok) begin
                hs_cyc[issued] = cyc;
                issued++;
            end
            @(negedge clk);
            if (issued < 4) addr = 32'(issued * 4);
            else req = 1'b0;
        end
        n_total++;
        if (resp != 4 || issued != 4) $display("FAIL b2b count: %0d responses %0d accepts, required 4/4", resp, issued);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic seen;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0;
        #1;
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL rst_mid hs0: addr_ok=%b required 1", addr_ok); else n_pass++;
        @(negedge clk);
        addr = 32'h4;
        #1;
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL rst_mid hs1: addr_ok=%b required 1", addr_ok); else n_pass++;
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        #1;
        n_total++;
        if (addr_ok !== 1'b0 || data_ok !== 1'b0)
            $display("FAIL rst_mid in reset: addr_ok=%b data_ok=%b required 0/0", addr_ok, data_ok);
        else n_pass++;
        @(negedge clk);
        #1;
        n_total++;
        if (addr_ok !== 1'b0 || data_ok !== 1'b0)
            $display("FAIL rst_mid held: addr_ok=%b data_ok=%b required 0/0", addr_ok, data_ok);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (data_ok !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (seen) $display("FAIL rst_mid dropped: data_ok=1 seen after release, required none");
        else n_pass++;
        #1;
        n_total++;
        if (addr_ok !== 1'b1) $display("FAIL rst_mid cnt clear: addr_ok=%b required 1", addr_ok); else n_pass++;
    endtask
`endif

    task automatic test_random();
        localparam int N = 1000;
        logic [31:0] model [16];
        logic [31:0] exp_q [$];
        int          hs_q [$];
        logic        active;
        logic        low_seen;
        logic [3:0]  st;
        logic [31:0] e;
        int          h;
        int          issued;
        int          done;
        int          cycles;
        int          idx;
        issued = 0; done = 0; cycles = 0; active = 1'b0; low_seen = 1'b0;
        while ((issued < N + 16 || done < issued) && cycles < 20000) begin
            @(negedge clk);
            if (!active && issued < N + 16) begin
                active = 1'b1;
                req = 1'b1;
                if (issued < 16) begin
                    wr = 1'b1; size = 2'd2;
                    addr = 32'h2000 + 32'(issued * 4);
                end else begin
                    wr = 1'($urandom_range(0, 1));
                    size = 2'($urandom_range(0, 3));
                    addr = 32'h2000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3))
                         + (32'($urandom_range(0, 3)) << 14);
                end
                wdata = $urandom;
            end else if (!active) begin
                req = 1'b0;
            end
            #1;
            if (addr_ok !== 1'b1) low_seen = 1'b1;
            if (data_ok === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand unexpected data_ok: rdata=%h, required no response", rdata);
                end else begin
                    e = exp_q.pop_front();
                    h = hs_q.pop_front();
                    if (rdata !== e || cyc - h != 3)
                        $display("FAIL rand resp %0d: rdata=%h latency %0d, required %h latency 3", done, rdata, cyc - h, e);
                    else n_pass++;
                end
                done++;
            end
            if (req && addr_ok) begin
                idx = int'(addr[5:2]);
                exp_q.push_back(model[idx]);
                hs_q.push_back(cyc);
                if (wr) begin
                    case (size)
                        2'd0:    st = 4'b0001 << addr[1:0];
                        2'd1:    st = addr[0] ? 4'b0000 : (4'b0011 << addr[1:0]);
                        default: st = (addr[1:0] != 2'b00) ? 4'b0000 : 4'b1111;
                    endcase
                    for (int b = 0; b < 4; b++)
                        if (st[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
                end
                issued++;
                active = 1'b0;
            end
            cycles++;
        end
        req = 1'b0;
        n_total++;
        if (done != N + 16 || exp_q.size() != 0)
            $display("FAIL rand count: %0d responses %0d pending, required %0d/0", done, exp_q.size(), N + 16);
        else n_pass++;
`ifdef SRAM_LIKE_STALL_INJECT_EN
        n_total++;
        if (!low_seen) $display("FAIL rand stall: addr_ok low seen=%b required 1", low_seen);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_strobe();
        test_misaligned();
`ifndef SRAM_LIKE_STALL_INJECT_EN
        test_back_to_back();
        test_reset_midflight();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
